sad_search_ctrl: RTL and testbench



---
 rtl/sad_search_ctrl.sv | 150 +++++++++++++++
 tb/tb_sad_search_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_search_ctrl.sv
// Block-matching SAD search sequencer: issues row fetches for every candidate
// block, accumulates the returned row SADs and tracks the best candidate.
module sad_search_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned INPUTS     = 4,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned CANDIDATES = 16,
  localparam int unsigned RW  = WIDTH + $clog2(INPUTS),
  localparam int unsigned SW  = RW + $clog2(ROWS),
  localparam int unsigned CW  = $clog2(CANDIDATES),
  localparam int unsigned RBW = $clog2(ROWS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           req_valid,
  input  logic           req_ready,
  output logic [CW-1:0]  req_cand,
  output logic [RBW-1:0] req_row,
  input  logic           row_valid,
  input  logic [RW-1:0]  row_sad,
  output logic [SW-1:0]  best_sad,
  output logic [CW-1:0]  best_idx,
  output logic           done
);

  localparam logic [CW-1:0]  LAST_CAND = CW'(CANDIDATES - 1);
  localparam logic [RBW-1:0] LAST_ROW  = RBW'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0]  rx_cand_q;
  logic [RBW-1:0] rx_row_q;
  logic [SW-1:0]  acc_q;

  logic           start_ok;
  logic           req_fire;
  logic           req_last;
  logic           rx_en;
  logic           rx_last_row;
  logic           rx_final;
  logic [SW-1:0]  acc_base;
  logic [SW-1:0]  acc_sum;

  // Handshake decode and running row-SAD accumulation.
  always_comb begin
    start_ok    = (state_q == S_IDLE) && start;
    req_fire    = req_valid && req_ready;
    req_last    = (req_cand == LAST_CAND) && (req_row == LAST_ROW);
    rx_en       = row_valid && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
    rx_last_row = (rx_row_q == LAST_ROW);
    rx_final    = rx_en && rx_last_row && (rx_cand_q == LAST_CAND);
    acc_base    = (rx_row_q == '0) ? '0 : acc_q;
    acc_sum     = acc_base + SW'(row_sad);
  end

  // Next-state logic for the search sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // The final result may land on the same edge as the final request.
        if (req_fire && req_last) state_d = rx_final ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (rx_final) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with registered status outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy      <= 1'b0;
      req_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy      <= (state_d == S_ISSUE) || (state_d == S_DRAIN);
      req_valid <= (state_d == S_ISSUE);
      done      <= (state_d == S_DONE);
    end
  end

  // Request counters: row-major walk, held while the datapath stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_cand <= '0;
      req_row  <= '0;
    end else if (start_ok) begin
      req_cand <= '0;
      req_row  <= '0;
    end else if (req_fire) begin
      if (req_row == LAST_ROW) begin
        req_row  <= '0;
        req_cand <= req_cand + CW'(1);
      end else begin
        req_row  <= req_row + RBW'(1);
      end
    end
  end

  // Result path: per-candidate accumulation and best-candidate tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cand_q <= '0;
      rx_row_q  <= '0;
      acc_q     <= '0;
      best_sad  <= '0;
      best_idx  <= '0;
    end else if (start_ok) begin
      rx_cand_q <= '0;
      rx_row_q  <= '0;
      acc_q     <= '0;
    end else if (rx_en) begin
      acc_q <= acc_sum;
      if (rx_last_row) begin
        rx_row_q  <= '0;
        rx_cand_q <= rx_cand_q + CW'(1);
        // Strict less-than keeps the lowest index on ties.
        if ((rx_cand_q == '0) || (acc_sum < best_sad)) begin
          best_sad <= acc_sum;
          best_idx <= rx_cand_q;
        end
      end else begin
        rx_row_q <= rx_row_q + RBW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Randomized bench for sad_search_ctrl with a latency-modelled datapath and a
// candidate-total reference model.
module tb_sad_search_ctrl;

  localparam int NW = 8;
  localparam int NI = 4;
  localparam int NR = 4;
  localparam int NC = 4;
  localparam int RW = 10;
  localparam int SW = 12;
  localparam int CW = 2;
  localparam int RBW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           busy;
  logic           req_valid;
  logic           req_ready;
  logic [CW-1:0]  req_cand;
  logic [RBW-1:0] req_row;
  logic           row_valid;
  logic [RW-1:0]  row_sad;
  logic [SW-1:0]  best_sad;
  logic [CW-1:0]  best_idx;
  logic           done;

  sad_search_ctrl #(
    .WIDTH(NW), .INPUTS(NI), .ROWS(NR), .CANDIDATES(NC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cand(req_cand), .req_row(req_row),
    .row_valid(row_valid), .row_sad(row_sad),
    .best_sad(best_sad), .best_idx(best_idx), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [RW-1:0] tbl [NC][NR];
  int            due_q [$];
  logic [RW-1:0] sad_q [$];
  int  last_due  = 0;
  int  ready_pct = 100;
  int  max_lat   = 1;
  bit  issuing   = 0;
  bit  in_search = 0;
  int  exp_c     = 0;
  int  exp_r     = 0;
  int  rx_cnt    = 0;
  int  fin_cyc   = -1000;
  int  done_cnt  = 0;
  int  done_cyc  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Lowest total wins; earlier index kept on ties.
  task automatic ref_best(output int bs, output int bi);
    int tot;
    bs = -1;
    bi = 0;
    for (int c = 0; c < NC; c++) begin
      tot = 0;
      for (int r = 0; r < NR; r++) tot += int'(tbl[c][r]);
      if (bs < 0 || tot < bs) begin
        bs = tot;
        bi = c;
      end
    end
  endtask

  // One clock: observe outputs at the falling edge, then drive the next inputs.
  task automatic step();
    int due;
    bit exp_done;
    @(negedge clk);
    cyc++;
    exp_done = in_search && (fin_cyc >= 0) && (cyc == fin_cyc + 1);
    check_eq("done", done, exp_done);
    check_eq("busy", busy, in_search && !exp_done);
    check_eq("req_valid", req_valid, issuing);
    if (issuing) begin
      check_eq("req_cand", req_cand, exp_c);
      check_eq("req_row", req_row, exp_r);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (exp_done) in_search = 0;

    req_ready = (int'($urandom_range(99)) < ready_pct);
    if (issuing && req_valid && req_ready) begin
      due = cyc + int'($urandom_range(max_lat, 1));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      due_q.push_back(due);
      sad_q.push_back(tbl[exp_c][exp_r]);
      exp_r++;
      if (exp_r == NR) begin
        exp_r = 0;
        exp_c++;
        if (exp_c == NC) issuing = 0;
      end
    end

    row_valid = 1'b0;
    row_sad   = RW'($urandom_range(1023));
    if (due_q.size() != 0 && due_q[0] == cyc) begin
      row_valid = 1'b1;
      row_sad   = sad_q.pop_front();
      void'(due_q.pop_front());
      if (in_search) begin
        rx_cnt++;
        if (rx_cnt == NC * NR) fin_cyc = cyc;
      end
    end
  endtask

  task automatic begin_search(input int rdy, input int lat);
    ready_pct = rdy;
    max_lat   = lat;
    done_cnt  = 0;
    fin_cyc   = -1000;
    rx_cnt    = 0;
    exp_c     = 0;
    exp_r     = 0;
    issuing   = 1;
    in_search = 1;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Full search; abuse_at >= 0 re-pulses start that many cycles in.
  task automatic run_search(input string name, input int rdy, input int lat,
                            input int abuse_at, input int exp_len);
    int s, bs, bi, b;
    ref_best(bs, bi);
    s = cyc;
    begin_search(rdy, lat);
    b = 0;
    while (in_search && b < 2000) begin
      if (b == abuse_at) start = 1'b1;
      step();
      start = 1'b0;
      b++;
    end
    check_eq({name, "_timeout"}, in_search, 0);
    check_eq({name, "_best_sad"}, best_sad, bs);
    check_eq({name, "_best_idx"}, best_idx, bi);
    if (exp_len > 0) check_eq({name, "_latency"}, done_cyc - s, exp_len);
    step();
    step();
    check_eq({name, "_done_count"}, done_cnt, 1);
  endtask

  task automatic fill_random(input int maxv);
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++)
        tbl[c][r] = RW'($urandom_range(maxv));
  endtask

  initial begin
    int b;
    rst = 1'b1;
    start = 1'b0;
    req_ready = 1'b0;
    row_valid = 1'b0;
    row_sad = '0;
    step();
    step();
    check_eq("rst_req_cand", req_cand, 0);
    check_eq("rst_req_row", req_row, 0);
    check_eq("rst_best_sad", best_sad, 0);
    check_eq("rst_best_idx", best_idx, 0);
    rst = 1'b0;
    step();

    // Basic sweep, one request per cycle, 1-cycle datapath.
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) tbl[c][r] = RW'(10 * (c + 1));
    run_search("sweep", 100, 1, -1, 18);

    // Minimum in the middle of the list.
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) tbl[c][r] = (c == 2) ? RW'(r + 1) : RW'(50);
    run_search("midmin", 100, 1, -1, 18);

    // Tie between candidates 1 and 3 with maximum-value neighbours.
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) tbl[c][r] = RW'(1020);
    tbl[1][0] = 1; tbl[1][1] = 2; tbl[1][2] = 3; tbl[1][3] = 1;
    tbl[3][0] = 0; tbl[3][1] = 0; tbl[3][2] = 0; tbl[3][3] = 7;
    run_search("tie", 100, 1, -1, 18);

    // All-maximum search.
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) tbl[c][r] = RW'(1020);
    run_search("allmax", 100, 1, -1, 18);
    check_eq("allmax_value", best_sad, 4080);

    // Back-pressure and variable latency, wide and narrow value ranges.
    for (int i = 0; i < 8; i++) begin
      fill_random((i % 2 == 0) ? 1020 : 3);
      run_search("stress", 50, 8, -1, 0);
    end

    // Start re-pulsed mid-search must be ignored.
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) tbl[c][r] = RW'(10 * (c + 1));
    run_search("restart", 100, 1, 5, 18);

    // Reset while request (2,1) is presented; stale results then arrive in IDLE.
    fill_random(1020);
    begin_search(100, 6);
    b = 0;
    while (!(exp_c == 2 && exp_r == 1) && b < 500) begin
      step();
      b++;
    end
    check_eq("abort_reached", (exp_c == 2 && exp_r == 1), 1);
    step();
    rst = 1'b1;
    in_search = 0;
    issuing = 0;
    step();
    rst = 1'b0;
    check_eq("abort_req_cand", req_cand, 0);
    check_eq("abort_req_row", req_row, 0);
    b = 0;
    while (due_q.size() != 0 && b < 500) begin
      step();
      b++;
    end
    step();
    check_eq("abort_best_sad", best_sad, 0);
    check_eq("abort_best_idx", best_idx, 0);
    check_eq("abort_no_done", done_cnt, 0);

    // Fresh search after the abort.
    fill_random(1020);
    run_search("fresh", 50, 4, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
